// File: rtl/alu_sched.sv
// alu_sched: round-robin scheduler sharing one combinational ALU between two requesters
// Ports: clk/rst_n (async, active-low); req_valid/req_ready, req_a/req_b/req_sel/req_acc per requester;
// alu_a/alu_b/alu_sel drive the shared ALU, alu_out/alu_carry come back; rsp_valid/rsp_ready with
// rsp_data/rsp_carry/rsp_id carry the captured result. Optional macro ALU_SCHED_ACC_EN adds an accumulator.
module alu_sched #(
   parameter int W = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [1:0]     req_valid,
   output logic [1:0]     req_ready,
   input  logic [2*W-1:0] req_a,
   input  logic [2*W-1:0] req_b,
   input  logic [5:0]     req_sel,
   input  logic [1:0]     req_acc,
   output logic [W-1:0]   alu_a,
   output logic [W-1:0]   alu_b,
   output logic [2:0]     alu_sel,
   input  logic [W-1:0]   alu_out,
   input  logic           alu_carry,
   output logic           rsp_valid,
   input  logic           rsp_ready,
   output logic [W-1:0]   rsp_data,
   output logic           rsp_carry,
   output logic           rsp_id
);
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
   state_t       state;
   logic         rr;
   logic         gnt;
   logic [W-1:0] op_a;
   // rr names the requester that wins a tie, i.e. the one not served last
   assign gnt       = (&req_valid) ? rr : req_valid[1];
   assign req_ready = (rst_n && state == IDLE && |req_valid) ? (gnt ? 2'b10 : 2'b01) : 2'b00;
   assign rsp_valid = state == RESP;
`ifdef ALU_SCHED_ACC_EN
   logic [W-1:0] acc;
   assign op_a = req_acc[gnt] ? acc : (gnt ? req_a[2*W-1:W] : req_a[W-1:0]);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) acc <= '0;
      else if (state == EXEC) acc <= alu_out;
`else
   logic unused_acc;
   assign unused_acc = ^req_acc;
   assign op_a = gnt ? req_a[2*W-1:W] : req_a[W-1:0];
`endif
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state     <= IDLE;
         rr        <= 1'b0;
         alu_a     <= '0;
         alu_b     <= '0;
         alu_sel   <= '0;
         rsp_data  <= '0;
         rsp_carry <= 1'b0;
         rsp_id    <= 1'b0;
      end else
         case (state)
            IDLE: if (|req_valid) begin
               state   <= EXEC;
               alu_a   <= op_a;
               alu_b   <= gnt ? req_b[2*W-1:W] : req_b[W-1:0];
               alu_sel <= gnt ? req_sel[5:3] : req_sel[2:0];
               rsp_id  <= gnt;
            end
            EXEC: begin
               state     <= RESP;
               rsp_data  <= alu_out;
               rsp_carry <= alu_carry;
            end
            RESP: if (rsp_ready) begin
               state <= IDLE;
               rr    <= ~rsp_id;
            end
            default: state <= IDLE;
         endcase
endmodule

// File: tb/tb_alu_sched.sv
// tb_alu_sched: scoreboard bench for alu_sched with an adder ALU stub
module tb_alu_sched;
   localparam int W = 8;
   logic           clk = 1'b0;
   logic           rst_n;
   logic [1:0]     req_valid = '0, req_ready, req_acc = '0;
   logic [2*W-1:0] req_a = '0, req_b = '0;
   logic [5:0]     req_sel = '0;
   logic [W-1:0]   alu_a, alu_b, alu_out, rsp_data;
   logic [2:0]     alu_sel;
   logic           alu_carry, rsp_valid, rsp_ready = 1'b1, rsp_carry, rsp_id;
   int             checks = 0, errors = 0;
   logic [W+1:0]   exp_q[$];
   logic [W+1:0]   e;
   always #5 clk = ~clk;
   assign {alu_carry, alu_out} = {1'b0, alu_a} + {1'b0, alu_b};
   alu_sched #(.W(W)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_sel(req_sel), .req_acc(req_acc),
      .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out), .alu_carry(alu_carry),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_carry(rsp_carry), .rsp_id(rsp_id)
   );
   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", n, act, exp);
      end
   endtask
   // response monitor: each handshake pops one expected {id, carry, data}
   always @(negedge clk)
      if (rst_n && rsp_valid && rsp_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL rsp_extra: got id=%0d data=%0h with nothing expected", rsp_id, rsp_data);
         end else begin
            e = exp_q.pop_front();
            if ({rsp_id, rsp_carry, rsp_data} !== e) begin
               errors++;
               $display("FAIL rsp: got %0h expected %0h", {rsp_id, rsp_carry, rsp_data}, e);
            end
         end
      end
   task automatic op(input int k, input logic [W-1:0] a, input logic [W-1:0] b, input logic acc,
                     input logic [2:0] sel, input logic [W:0] r);
      req_valid    = '0;
      req_valid[k] = 1'b1;
      req_acc      = '0;
      req_acc[k]   = acc;
      if (k == 0) begin
         req_a[W-1:0] = a; req_b[W-1:0] = b; req_sel[2:0] = sel;
      end else begin
         req_a[2*W-1:W] = a; req_b[2*W-1:W] = b; req_sel[5:3] = sel;
      end
      exp_q.push_back({k[0], r});
      @(negedge clk); chk("grant", req_ready, k == 0 ? 1 : 2);
      @(posedge clk); #1 req_valid = '0;
      @(negedge clk);
      chk("exec_valid", rsp_valid, 0);
      chk("alu_b", alu_b, b);
      chk("alu_sel", alu_sel, sel);
      @(negedge clk); chk("resp_valid", rsp_valid, 1);
      @(posedge clk); #1;
   endtask
   initial begin
      #100000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end
   initial begin
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      req_valid = 2'b11;
      #1;
      chk("rst_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_alu_a", alu_a, 0);
      chk("rst_alu_sel", alu_sel, 0);
      req_valid = '0;
      @(posedge clk); #1 rst_n = 1'b1;
      op(0, 8'd10, 8'd5, 1'b0, 3'b101, 9'd15);
      op(1, 8'hF0, 8'h20, 1'b0, 3'b000, 9'h110);
      req_a = {8'd2, 8'd1};
      req_b = {8'd2, 8'd1};
      req_valid = 2'b11;
      for (int i = 0; i < 4; i++) exp_q.push_back({i[0], 1'b0, (i % 2 != 0) ? 8'd4 : 8'd2});
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); chk("cont_grant", req_ready, (i % 2 != 0) ? 2 : 1);
         @(negedge clk); chk("cont_exec_ready", req_ready, 0);
         @(negedge clk); chk("cont_resp_ready", req_ready, 0);
      end
      @(posedge clk); #1 req_valid = '0;
      rsp_ready = 1'b0;
      req_a[7:0] = 8'h55;
      req_b[7:0] = 8'h11;
      req_valid = 2'b01;
      exp_q.push_back({1'b0, 9'h066});
      @(posedge clk); #1 req_valid = 2'b10;
      @(posedge clk);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_valid", rsp_valid, 1);
         chk("bp_data", rsp_data, 8'h66);
         chk("bp_ready", req_ready, 0);
      end
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      req_valid = '0;
      @(posedge clk); #1;
      @(negedge clk);
      chk("bp_done_valid", rsp_valid, 0);
      chk("bp_one_rsp", exp_q.size(), 0);
      @(posedge clk); #1;
      req_a[15:8] = 8'd9;
      req_b[15:8] = 8'd9;
      req_valid = 2'b10;
      @(posedge clk); #1 req_valid = '0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst_exec_valid", rsp_valid, 0);
      chk("rst_exec_alu_a", alu_a, 0);
      @(posedge clk); #1 rst_n = 1'b1;
      req_a = {8'd7, 8'h20};
      req_b = {8'd7, 8'h22};
      req_valid = 2'b11;
      exp_q.push_back({1'b0, 9'h042});
      @(negedge clk);
      chk("rst_rr_grant", req_ready, 1);
      chk("rst_idle_valid", rsp_valid, 0);
      @(posedge clk); #1 req_valid = '0;
      @(posedge clk);
      @(negedge clk); chk("post_rst_resp", rsp_valid, 1);
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      req_a[15:8] = 8'd9;
      req_b[15:8] = 8'd9;
      req_valid = 2'b10;
      @(posedge clk); #1 req_valid = '0;
      @(posedge clk);
      @(negedge clk);
      chk("pre_rst_resp_valid", rsp_valid, 1);
      chk("pre_rst_resp_data", rsp_data, 8'h12);
      #1 rst_n = 1'b0;
      #1;
      chk("rst_resp_valid", rsp_valid, 0);
      chk("rst_resp_data", rsp_data, 0);
      chk("rst_resp_id", rsp_id, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      rsp_ready = 1'b1;
      op(0, 8'd3, 8'd4, 1'b0, 3'b000, 9'd7);
`ifdef ALU_SCHED_ACC_EN
      op(1, 8'd1, 8'd2, 1'b1, 3'b000, 9'd9);
`else
      op(1, 8'd1, 8'd2, 1'b1, 3'b000, 9'd3);
`endif
      repeat (3) @(negedge clk);
      chk("no_extra_rsp", rsp_valid, 0);
      chk("queue_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
